// File: rtl/mult_seq32_pkg.sv
// Shared constants and state encoding for the sequential 32x32 shift-add multiplier.
package mult_seq32_pkg;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned MULT_ITER  = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONES = 3'd4
  } state_t;

endpackage

// File: rtl/twoscomp32.sv
// Combinational two's complement (negation) of a 32-bit word.
module twoscomp32 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_y
);

  assign o_y = W'(~i_x) + W'(1);

endmodule

// File: rtl/twoscomp64.sv
// Combinational two's complement (negation) of a 64-bit word.
module twoscomp64 #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_y
);

  assign o_y = W'(~i_x) + W'(1);

endmodule

// File: rtl/mult_seq32.sv
// Sequential shift-add multiplier, one product bit per cycle, signed or unsigned.
// Operates on the falling clock edge to line up with the register-file family.
module mult_seq32
  import mult_seq32_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH,
  parameter int unsigned ITER  = MULT_ITER
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned PW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(ITER + 1);

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_busy;
  logic               w_done;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_signed;
  logic               r_neg;
  logic [WIDTH-1:0]   r_m;
  logic [PW-1:0]      r_p;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_a_neg;
  logic [WIDTH-1:0]   w_b_neg;
  logic [2*WIDTH-1:0] w_p_neg;
  logic [WIDTH:0]     w_sum;
  logic [PW-1:0]      w_p_step;

  twoscomp32 #(.W(WIDTH)) u_neg_a (
    .i_x (r_a),
    .o_y (w_a_neg)
  );

  twoscomp32 #(.W(WIDTH)) u_neg_b (
    .i_x (r_b),
    .o_y (w_b_neg)
  );

  twoscomp64 #(.W(2 * WIDTH)) u_neg_p (
    .i_x (r_p[2*WIDTH-1:0]),
    .o_y (w_p_neg)
  );

  // One iteration: conditional 33-bit add into the upper half, then logical shift right.
  assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
  assign w_p_step = r_p[0] ? ({w_sum, r_p[WIDTH-1:0]} >> 1) : (r_p >> 1);

  always_ff @(negedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_accept = 1'b1;
          w_next   = ST_PREP;
        end
      end
      ST_PREP:  w_next = ST_RUN;
      ST_RUN: begin
        if (r_cnt == CW'(ITER - 1)) w_next = ST_FIX;
      end
      ST_FIX:   w_next = ST_DONES;
      ST_DONES: begin
        if (START) begin
          w_accept = 1'b1;
          w_next   = ST_PREP;
        end else begin
          w_next   = ST_IDLE;
        end
      end
      default:  w_next = ST_IDLE;
    endcase
    w_busy = (w_next == ST_PREP) || (w_next == ST_RUN) || (w_next == ST_FIX);
    w_done = (w_next == ST_DONES);
  end

  // Datapath: operand capture, magnitude prep, iterate, sign-fix into HI/LO.
  always_ff @(negedge CLK) begin
    if (RESET) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_neg    <= 1'b0;
      r_m      <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= A;
        r_b      <= B;
        r_signed <= SIGNED;
        r_neg    <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
      end
      case (r_state)
        ST_PREP: begin
          r_m   <= (r_signed & r_a[WIDTH-1]) ? w_a_neg : r_a;
          r_p   <= {(WIDTH + 1)'(0), ((r_signed & r_b[WIDTH-1]) ? w_b_neg : r_b)};
          r_cnt <= '0;
        end
        ST_RUN: begin
          r_p   <= w_p_step;
          r_cnt <= r_cnt + CW'(1);
        end
        ST_FIX: begin
          {r_hi, r_lo} <= r_neg ? w_p_neg : r_p[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mult_seq32.sv
// Directed bench for mult_seq32: vector table plus collision, reset and back-to-back sequences.
module tb_mult_seq32;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic        SIGNED;
  logic [31:0] A;
  logic [31:0] B;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_vec  = 0;
  int n_fail = 0;

  mult_seq32 dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .SIGNED (SIGNED),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .HI     (HI),
    .LO     (LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // DUT updates on negedge; the bench drives and samples on posedge.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!DONE && lat < 100) begin
      if (BUSY) busy_cnt++;
      @(negedge CLK);
      lat++;
      @(posedge CLK);
    end
  endtask

  task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b);
    @(posedge CLK);
    START = 1'b1; SIGNED = sg; A = a; B = b;
    @(negedge CLK);
    @(posedge CLK);
    START = 1'b0; A = '0; B = '0; SIGNED = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge CLK);
      @(posedge CLK);
      if (DONE) pulses++;
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int pulses;
    logic [63:0] held;

    vecs[0]  = '{1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A};
    vecs[1]  = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[3]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[4]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[5]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{1'b1, 32'h0001_2345, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFD_B976};
    vecs[10] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

    RESET = 1'b1; START = 1'b0; SIGNED = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    chk("reset_busy", 64'(BUSY), 64'd0);
    chk("reset_done", 64'(DONE), 64'd0);
    chk("reset_hilo", {HI, LO}, 64'd0);
    RESET = 1'b0;

    for (int i = 0; i < NV; i++) begin
      launch(vecs[i].sg, vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd34);
      chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd34);
      chk($sformatf("v%0d_busy_at_done", i), 64'(BUSY), 64'd0);
      chk($sformatf("v%0d_hilo", i), {HI, LO}, {vecs[i].hi, vecs[i].lo});
      @(negedge CLK);
      @(posedge CLK);
      chk($sformatf("v%0d_done_one_cycle", i), 64'(DONE), 64'd0);
    end

    held = {HI, LO};
    count_done(5, pulses);
    chk("idle_hold_hilo", {HI, LO}, held);
    chk("idle_no_done", 64'(pulses), 64'd0);

    // START while busy must be ignored.
    launch(1'b0, 32'd3, 32'd4);
    for (int k = 1; k < 10; k++) begin
      @(negedge CLK);
      @(posedge CLK);
    end
    START = 1'b1; SIGNED = 1'b1; A = 32'd9; B = 32'd9;
    @(negedge CLK);
    @(posedge CLK);
    START = 1'b0; A = '0; B = '0; SIGNED = 1'b0;
    wait_done(lat, bcnt);
    chk("coll_latency", 64'(lat), 64'd24);
    chk("coll_hilo", {HI, LO}, 64'd12);
    count_done(40, pulses);
    chk("coll_single_done", 64'(pulses), 64'd0);
    launch(1'b0, 32'd2, 32'd3);
    wait_done(lat, bcnt);
    chk("coll_next_latency", 64'(lat), 64'd34);
    chk("coll_next_hilo", {HI, LO}, 64'd6);

    // Reset in the middle of RUN aborts and clears the result.
    launch(1'b0, 32'd7, 32'd7);
    for (int k = 1; k < 10; k++) begin
      @(negedge CLK);
      @(posedge CLK);
    end
    RESET = 1'b1;
    @(negedge CLK);
    @(posedge CLK);
    RESET = 1'b0;
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    count_done(40, pulses);
    chk("rst_no_done", 64'(pulses), 64'd0);
    launch(1'b0, 32'd2, 32'd2);
    wait_done(lat, bcnt);
    chk("rst_after_latency", 64'(lat), 64'd34);
    chk("rst_after_hilo", {HI, LO}, 64'd4);

    // Back-to-back: restart during the DONE cycle.
    launch(1'b0, 32'd3, 32'd3);
    wait_done(lat, bcnt);
    chk("b2b_first_latency", 64'(lat), 64'd34);
    chk("b2b_first_hilo", {HI, LO}, 64'd9);
    START = 1'b1; SIGNED = 1'b0; A = 32'd5; B = 32'd5;
    @(negedge CLK);
    @(posedge CLK);
    START = 1'b0; A = '0; B = '0;
    chk("b2b_busy_after_accept", 64'(BUSY), 64'd1);
    chk("b2b_done_dropped", 64'(DONE), 64'd0);
    chk("b2b_hold_first", {HI, LO}, 64'd9);
    wait_done(lat, bcnt);
    chk("b2b_second_latency", 64'(lat), 64'd34);
    chk("b2b_second_hilo", {HI, LO}, 64'd25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
